// File: rtl/fast_pkg.sv
// Shared types and helpers for the FAST segment tester.
package fast_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned RING_LEN = 16;
  localparam int unsigned SCORE_W  = 12;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [4:0]       run_t;

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} seg_state_t;

  function automatic run_t run_max(input run_t a, input run_t b);
    return (a > b) ? a : b;
  endfunction

  // Join the tail run at idx 15 with the lead run from idx 0 unless the ring matched everywhere.
  function automatic run_t close_arc(input run_t mx, input run_t cur, input run_t lead);
    if ((cur != 5'd0) && (lead != 5'(RING_LEN)))
      return run_max(mx, cur + lead);
    return mx;
  endfunction

endpackage

// File: rtl/fast_pixel_classifier.sv
// Combinational bright/dark classification of one ring pixel against centre +/- threshold.
module fast_pixel_classifier #(
  parameter int unsigned PIX_W = 8
) (
  input  logic [PIX_W-1:0] p,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] t,
  output logic             bright,
  output logic             dark,
  output logic [PIX_W-1:0] abs_diff
);

  localparam int unsigned EXT_W = PIX_W + 2;

  logic signed [EXT_W-1:0] p_e, c_e, t_e, hi, lo;

  // Two guard bits keep c+t and c-t exact; a negative c-t makes dark impossible.
  assign p_e = $signed(EXT_W'(p));
  assign c_e = $signed(EXT_W'(c));
  assign t_e = $signed(EXT_W'(t));
  assign hi  = c_e + t_e;
  assign lo  = c_e - t_e;

  assign bright   = p_e > hi;
  assign dark     = p_e < lo;
  assign abs_diff = (p > c) ? (p - c) : (c - p);

endmodule

// File: rtl/fast_segment_tester.sv
// FAST segment test over one 16-pixel Bresenham ring, with wrap-around arc detection.
// Optional score accumulation is enabled by defining FAST_SCORE_EN.
module fast_segment_tester #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned ARC_LEN = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PIX_W-1:0] center_pixel,
  input  logic [PIX_W-1:0] threshold,
  input  logic             sample_valid,
  input  logic [PIX_W-1:0] sample_pixel,
  output logic             busy,
  output logic             done,
  output logic             is_corner,
  output logic             polarity,
  output logic [4:0]       max_run,
  output logic [11:0]      score
);

  import fast_pkg::*;

  seg_state_t       state, state_nxt;
  logic [PIX_W-1:0] c_q, t_q;
  logic [3:0]       idx;
  run_t             cur_b, cur_d, lead_b, lead_d, max_b, max_d;
  logic             lead_b_open, lead_d_open;
  logic             bright, dark;
  logic [PIX_W-1:0] abs_diff;
  logic             load_c, samp_c, eval_c;
  run_t             fin_b, fin_d, run_c;
  logic             pol_c, corner_c;

  fast_pixel_classifier #(.PIX_W(PIX_W)) u_class (
    .p        (sample_pixel),
    .c        (c_q),
    .t        (t_q),
    .bright   (bright),
    .dark     (dark),
    .abs_diff (abs_diff)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (start) state_nxt = COLLECT;
               else if (sample_valid && (idx == 4'd15)) state_nxt = EVAL;
      EVAL:    state_nxt = start ? COLLECT : DONE;
      DONE:    state_nxt = start ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start restarts from any state and takes priority over a coincident sample.
  always_comb begin
    load_c = 1'b0;
    samp_c = 1'b0;
    eval_c = 1'b0;
    if (start) load_c = 1'b1;
    else if ((state == COLLECT) && sample_valid) samp_c = 1'b1;
    else if (state == EVAL) eval_c = 1'b1;
  end

  always_comb begin
    fin_b    = close_arc(max_b, cur_b, lead_b);
    fin_d    = close_arc(max_d, cur_d, lead_d);
    pol_c    = fin_b >= fin_d;
    run_c    = pol_c ? fin_b : fin_d;
    corner_c = run_c >= run_t'(ARC_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      is_corner   <= 1'b0;
      polarity    <= 1'b0;
      max_run     <= '0;
      c_q         <= '0;
      t_q         <= '0;
      idx         <= '0;
      cur_b       <= '0;
      cur_d       <= '0;
      lead_b      <= '0;
      lead_d      <= '0;
      max_b       <= '0;
      max_d       <= '0;
      lead_b_open <= 1'b0;
      lead_d_open <= 1'b0;
    end else begin
      busy <= (state_nxt == COLLECT) || (state_nxt == EVAL);
      done <= eval_c;
      if (load_c) begin
        c_q         <= center_pixel;
        t_q         <= threshold;
        idx         <= '0;
        cur_b       <= '0;
        cur_d       <= '0;
        lead_b      <= '0;
        lead_d      <= '0;
        max_b       <= '0;
        max_d       <= '0;
        lead_b_open <= 1'b1;
        lead_d_open <= 1'b1;
      end else if (samp_c) begin
        idx <= idx + 4'd1;
        if (bright) begin
          cur_b <= cur_b + 5'd1;
          max_b <= run_max(max_b, cur_b + 5'd1);
          if (lead_b_open) lead_b <= lead_b + 5'd1;
        end else begin
          cur_b       <= '0;
          lead_b_open <= 1'b0;
        end
        if (dark) begin
          cur_d <= cur_d + 5'd1;
          max_d <= run_max(max_d, cur_d + 5'd1);
          if (lead_d_open) lead_d <= lead_d + 5'd1;
        end else begin
          cur_d       <= '0;
          lead_d_open <= 1'b0;
        end
      end
      if (eval_c) begin
        is_corner <= corner_c;
        polarity  <= pol_c;
        max_run   <= run_c;
      end
    end
  end

`ifdef FAST_SCORE_EN
  logic [11:0] acc_b, acc_d;
  logic [12:0] inc;

  assign inc = 13'(abs_diff - t_q);

  // Per-polarity sums of (|p-c| - t), saturating at 12'hFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_b <= '0;
      acc_d <= '0;
      score <= '0;
    end else begin
      if (load_c) begin
        acc_b <= '0;
        acc_d <= '0;
      end else if (samp_c) begin
        if (bright) acc_b <= (13'(acc_b) + inc > 13'hFFF) ? 12'hFFF : 12'(13'(acc_b) + inc);
        if (dark)   acc_d <= (13'(acc_d) + inc > 13'hFFF) ? 12'hFFF : 12'(13'(acc_d) + inc);
      end
      if (eval_c) score <= corner_c ? (pol_c ? acc_b : acc_d) : 12'h000;
    end
  end
`else
  logic unused_abs;
  assign unused_abs = ^abs_diff;
  assign score      = 12'h000;
`endif

endmodule

// File: tb/tb_fast_segment_tester.sv
// Scoreboard bench for fast_segment_tester: reference arc model, latency, abort and reset checks.
module tb_fast_segment_tester;

  localparam int ARC_LEN = 9;

  logic        clk = 1'b0;
  logic        rst, start, sample_valid;
  logic [7:0]  center_pixel, threshold, sample_pixel;
  logic        busy, done, is_corner, polarity;
  logic [4:0]  max_run;
  logic [11:0] score;

  typedef struct packed {
    logic        corner;
    logic        pol;
    logic [4:0]  run;
    logic [11:0] score;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         done_cnt = 0;
  logic [7:0] ring [16];

  fast_segment_tester #(.PIX_W(8), .ARC_LEN(ARC_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .center_pixel(center_pixel),
    .threshold(threshold), .sample_valid(sample_valid), .sample_pixel(sample_pixel),
    .busy(busy), .done(done), .is_corner(is_corner), .polarity(polarity),
    .max_run(max_run), .score(score)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference: longest circular run found by scanning from every start index.
  function automatic exp_t model(input logic [7:0] c, input logic [7:0] t);
    exp_t e;
    bit   fl [2][16];
    int   best [2];
    int   len, acc, d, win;
    bit   stop;
    for (int i = 0; i < 16; i++) begin
      fl[1][i] = int'(ring[i]) > int'(c) + int'(t);
      fl[0][i] = int'(ring[i]) < int'(c) - int'(t);
    end
    for (int pp = 0; pp < 2; pp++) begin
      best[pp] = 0;
      for (int s = 0; s < 16; s++) begin
        len = 0; stop = 0;
        for (int k = 0; k < 16; k++)
          if (!stop && fl[pp][(s + k) % 16]) len++; else stop = 1;
        if (len > best[pp]) best[pp] = len;
      end
    end
    e.pol    = best[1] >= best[0];
    win      = e.pol ? 1 : 0;
    e.run    = 5'(best[win]);
    e.corner = best[win] >= ARC_LEN;
    e.score  = 12'h000;
`ifdef FAST_SCORE_EN
    if (e.corner) begin
      acc = 0;
      for (int i = 0; i < 16; i++)
        if (fl[win][i]) begin
          d = int'(ring[i]) - int'(c);
          if (d < 0) d = -d;
          acc += d - int'(t);
        end
      if (acc > 4095) acc = 4095;
      e.score = 12'(acc);
    end
`endif
    return e;
  endfunction

  // Runs one candidate from the current ring; collide drives a junk sample alongside start.
  task automatic run_ring(input logic [7:0] c, input logic [7:0] t, input bit collide);
    exp_t e, got;
    sb.push_back(model(c, t));
    start = 1'b1; center_pixel = c; threshold = t;
    sample_valid = collide; sample_pixel = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample_valid = 1'b1; sample_pixel = ring[i];
      @(posedge clk); #1;
      if (i == 8) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_collect: got %b want 1", busy); end
      end
    end
    sample_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL done_early: got %b want 0", done); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL done_latency: got %b want 1", done); end
    got = {is_corner, polarity, max_run, score};
    e = sb.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL result c=%0d t=%0d: got corner=%b pol=%b run=%0d score=%0d want corner=%b pol=%b run=%0d score=%0d",
               c, t, got.corner, got.pol, got.run, got.score, e.corner, e.pol, e.run, e.score);
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_done: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) ring[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sample_valid = 1'b0;
    center_pixel = '0; threshold = '0; sample_pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, is_corner, polarity, max_run, score} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, is_corner, polarity, max_run, score});
    end
    rst = 1'b0;
    sample_valid = 1'b1; sample_pixel = 8'hC8;
    repeat (3) @(posedge clk);
    #1;
    sample_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      miscompares++;
      $display("FAIL idle_ignores_samples: got busy=%b dones=%0d want 0 0", busy, done_cnt);
    end
  endtask

  task automatic test_patterns();
    fill(8'd200); run_ring(8'd100, 8'd20, 0);
    fill(8'd100);
    for (int i = 12; i < 16; i++) ring[i] = 8'd200;
    for (int i = 0; i < 5; i++) ring[i] = 8'd200;
    run_ring(8'd100, 8'd20, 0);
    fill(8'd100);
    for (int i = 3; i <= 10; i++) ring[i] = 8'd10;
    run_ring(8'd100, 8'd20, 0);
  endtask

  task automatic test_saturation();
    fill(8'd255); run_ring(8'd250, 8'd10, 0);
    fill(8'd0);   run_ring(8'd5, 8'd10, 0);
  endtask

  task automatic test_score();
    fill(8'd150); run_ring(8'd100, 8'd20, 0);
  endtask

  task automatic test_abort_start();
    int d0;
    d0 = done_cnt;
    start = 1'b1; center_pixel = 8'd100; threshold = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_valid = 1'b1; sample_pixel = 8'd10;
      @(posedge clk); #1;
    end
    fill(8'd200);
    run_ring(8'd100, 8'd20, 1);
    vectors++;
    if (done_cnt != d0 + 1) begin
      miscompares++;
      $display("FAIL abort_start_dones: got %0d want %0d", done_cnt - d0, 1);
    end
  endtask

  task automatic test_abort_rst();
    int d0;
    d0 = done_cnt;
    start = 1'b1; center_pixel = 8'd100; threshold = 8'd20;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_pixel = 8'd200;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, is_corner, polarity, max_run, score} !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_abort_outputs: got %h want 0", {busy, done, is_corner, polarity, max_run, score});
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL rst_abort_dones: got %0d want 0", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, t;
    int s, l;
    for (int n = 0; n < 8; n++) begin
      c = 8'($urandom_range(40, 200));
      t = 8'($urandom_range(0, 35));
      s = $urandom_range(0, 15);
      l = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) ring[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < l; k++)
        ring[(s + k) % 16] = (n % 2 == 0) ? 8'(c + t + 8'd1 + 8'(k)) : 8'(c - t - 8'd1 - 8'(k % 4));
      run_ring(c, t, 0);
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_saturation();
    test_score();
    test_abort_start();
    test_abort_rst();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
